// File: rtl/data_cache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
// Address split: [1:0] byte, [3:2] word, then index, then tag.
package data_cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REFILL  = 2'd1,
    S_RESPOND = 2'd2,
    S_WRITE   = 2'd3
  } dc_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int OFFSET_W = 4;

  function automatic int index_width(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_width(input int addr_w, input int sets);
    return addr_w - OFFSET_W - $clog2(sets);
  endfunction

endpackage

// File: rtl/data_cache_mem_align.sv
// Combinational RISC-V load extract and store lane positioning.
// One instance serves hit, RESPOND and store-accept paths of the cache.
module mem_align
  import data_cache_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

    // Reserved encodings fall through to full-word behaviour.
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_BU:   o_rdata = {24'h000000, w_byte};
      F3_HU:   o_rdata = {16'h0000, w_half};
      default: o_rdata = i_word;
    endcase

    case (i_funct3)
      F3_B: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_wstrb = 4'b0001 << i_addr;
      end
      F3_H: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_wstrb = i_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        o_wdata = i_wdata;
        o_wstrb = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with 4-word
// lines refilled from a word-wide backing memory on load misses.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int SETS       = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [2:0]            i_cpu_ctrl,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  output logic                  o_cpu_ready,
  output logic                  o_cpu_rvalid,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [3:0]            o_mem_wstrb,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int IDX_W = index_width(SETS);
  localparam int TAG_W = tag_width(ADDR_WIDTH, SETS);

  dc_state_e r_state, w_state_nxt;

  logic                  r_valid [SETS];
  logic [TAG_W-1:0]      r_tag   [SETS];
  logic [DATA_WIDTH-1:0] r_data  [SETS][4];

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_f3;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_wstrb;
  logic [1:0]            r_issue_cnt;
  logic [1:0]            r_ret_cnt;
  logic                  r_issue_done;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [IDX_W-1:0]      w_idx_in, r_idx;
  logic [TAG_W-1:0]      w_tag_in, r_tag_lat;
  logic [1:0]            w_word_in, r_word;
  logic                  w_idle, w_hit, w_accept, w_issue, w_last_ret;
  logic [DATA_WIDTH-1:0] w_al_word, w_al_rdata, w_al_wdata;
  logic [1:0]            w_al_addr;
  logic [2:0]            w_al_f3;
  logic [3:0]            w_al_wstrb;

  assign w_idx_in  = i_cpu_addr[OFFSET_W +: IDX_W];
  assign w_tag_in  = i_cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_word_in = i_cpu_addr[3:2];
  assign r_idx     = r_addr[OFFSET_W +: IDX_W];
  assign r_tag_lat = r_addr[ADDR_WIDTH-1 -: TAG_W];
  assign r_word    = r_addr[3:2];

  assign w_idle     = (r_state == S_IDLE);
  assign w_hit      = r_valid[w_idx_in] && (r_tag[w_idx_in] == w_tag_in);
  assign w_accept   = i_cpu_req && w_idle;
  assign w_issue    = o_mem_req && i_mem_ready && (r_state == S_REFILL);
  assign w_last_ret = i_mem_rvalid && (r_ret_cnt == 2'd3) && (r_state == S_REFILL);

  // The aligner sees the live request in IDLE and the latched miss otherwise.
  assign w_al_word = w_idle ? r_data[w_idx_in][w_word_in] : r_data[r_idx][r_word];
  assign w_al_addr = w_idle ? i_cpu_addr[1:0] : r_addr[1:0];
  assign w_al_f3   = w_idle ? i_cpu_ctrl : r_f3;

  mem_align u_align (
    .i_word   (w_al_word),
    .i_addr   (w_al_addr),
    .i_funct3 (w_al_f3),
    .i_wdata  (i_cpu_wdata),
    .o_rdata  (w_al_rdata),
    .o_wdata  (w_al_wdata),
    .o_wstrb  (w_al_wstrb)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_cpu_ready = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cpu_ready = 1'b1;
        if (i_cpu_req) begin
          if (i_cpu_we)    w_state_nxt = S_WRITE;
          else if (!w_hit) w_state_nxt = S_REFILL;
        end
      end
      S_REFILL: begin
        o_mem_req = !r_issue_done;
        if (w_last_ret) w_state_nxt = S_RESPOND;
      end
      S_RESPOND: w_state_nxt = S_IDLE;
      S_WRITE: begin
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
        if (i_mem_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_mem_addr   = (r_state == S_REFILL) ? {r_addr[ADDR_WIDTH-1:4], r_issue_cnt, 2'b00}
                                              : {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign o_mem_wdata  = r_wdata;
  assign o_mem_wstrb  = r_wstrb;
  assign o_cpu_rvalid = r_rvalid || (r_state == S_RESPOND);
  assign o_cpu_rdata  = (r_state == S_RESPOND) ? w_al_rdata : r_rdata;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int s = 0; s < SETS; s++) r_valid[s] <= 1'b0;
      r_addr       <= '0;
      r_f3         <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_issue_cnt  <= '0;
      r_ret_cnt    <= '0;
      r_issue_done <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_rvalid <= 1'b0;
      if (w_accept) begin
        r_addr       <= i_cpu_addr;
        r_f3         <= i_cpu_ctrl;
        r_wdata      <= w_al_wdata;
        r_wstrb      <= w_al_wstrb;
        r_issue_cnt  <= '0;
        r_ret_cnt    <= '0;
        r_issue_done <= 1'b0;
        if (!i_cpu_we && w_hit) begin
          r_rvalid <= 1'b1;
          r_rdata  <= w_al_rdata;
        end
      end
      if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + 2'd1;
        if (r_issue_cnt == 2'd3) r_issue_done <= 1'b1;
      end
      if (i_mem_rvalid && (r_state == S_REFILL)) r_ret_cnt <= r_ret_cnt + 2'd1;
      if (w_last_ret) r_valid[r_idx] <= 1'b1;
    end
  end

  // Line storage carries no reset; the valid bits alone decide what is live.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      if (w_accept && i_cpu_we && w_hit) begin
        for (int b = 0; b < 4; b++)
          if (w_al_wstrb[b]) r_data[w_idx_in][w_word_in][8*b +: 8] <= w_al_wdata[8*b +: 8];
      end
      if (i_mem_rvalid && (r_state == S_REFILL)) begin
        r_data[r_idx][r_ret_cnt] <= i_mem_rdata;
        if (r_ret_cnt == 2'd3) r_tag[r_idx] <= r_tag_lat;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios followed by random
// loads/stores against a word-array reference memory and tag/valid model.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [2:0]  cpu_ctrl = 3'b010;
  logic [11:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ready, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b1, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  data_cache dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_ctrl(cpu_ctrl),
    .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ready(cpu_ready), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
    .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Backing memory (what the DUT wrote) and reference memory (what it should hold).
  logic [31:0] bmem    [1024];
  logic [31:0] ref_mem [1024];
  bit          m_valid [16];
  logic [3:0]  m_tag   [16];

  typedef struct { logic [11:0] a; int due; } rd_t;
  typedef struct { logic [11:0] a; logic [31:0] d; logic [3:0] s; } wr_t;
  rd_t         rq[$];
  logic [11:0] rdlog[$];
  wr_t         wlog[$];
  int          cyc = 0, rets = 0, mem_lat = 2, low_cnt = 0;
  bit          rand_ready = 0;

  always @(negedge clk) begin
    cyc++;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = bmem[rq[0].a[11:2]];
      void'(rq.pop_front());
      rets++;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    if (low_cnt > 0) begin
      mem_ready = 1'b0;
      low_cnt--;
    end else begin
      mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    #1;
    if (rst === 1'b1 && mem_req === 1'b1 && mem_ready) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) bmem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        wlog.push_back('{mem_addr, mem_wdata, mem_wstrb});
      end else begin
        rq.push_back('{mem_addr, cyc + mem_lat});
        rdlog.push_back(mem_addr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80)   ? b - 32'h100   : b;
      3'b001:  return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_strb(input logic [1:0] a, input logic [2:0] f3);
    case (f3)
      3'b000:  return 4'(1 << a);
      3'b001:  return a[1] ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_pos(input logic [31:0] d, input logic [1:0] a, input logic [2:0] f3);
    case (f3)
      3'b000:  return (d & 32'hFF) << (8 * a);
      3'b001:  return (d & 32'hFFFF) << (16 * a[1]);
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
    return m;
  endfunction

  task automatic do_load(input logic [11:0] a, input logic [2:0] f3, input string tg);
    bit          exp_hit;
    int          nrd0, n;
    logic [31:0] exp;
    logic [11:0] base;
    int          idx;
    idx     = int'(a[7:4]);
    exp_hit = m_valid[idx] && (m_tag[idx] == a[11:8]);
    exp     = ref_load(ref_mem[a[11:2]], a[1:0], f3);
    base    = {a[11:4], 4'h0};
    nrd0    = rdlog.size();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_ctrl = f3; cpu_addr = a;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    if (exp_hit) begin
      chk({tg, "_hit_rvalid"}, 32'(cpu_rvalid), 32'd1);
      chk({tg, "_hit_rdata"}, cpu_rdata, exp);
      chk({tg, "_hit_nomem"}, 32'(rdlog.size() - nrd0), 32'd0);
    end else begin
      n = 0;
      while (cpu_rvalid !== 1'b1 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      chk({tg, "_miss_rvalid"}, 32'(cpu_rvalid), 32'd1);
      chk({tg, "_miss_rdata"}, cpu_rdata, exp);
      chk({tg, "_miss_nreq"}, 32'(rdlog.size() - nrd0), 32'd4);
      if (rdlog.size() - nrd0 == 4)
        for (int k = 0; k < 4; k++)
          chk({tg, "_miss_addr"}, 32'(rdlog[nrd0 + k]), 32'(base + 12'(4 * k)));
      @(posedge clk); #1;
      chk({tg, "_miss_pulse"}, {30'd0, cpu_rvalid, cpu_ready}, 32'd1);
      m_valid[idx] = 1;
      m_tag[idx]   = a[11:8];
    end
  endtask

  task automatic do_store(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] d,
                          input int low, input string tg);
    int          nw0, nrd0, busy, n;
    bit          rv_seen;
    logic [3:0]  es;
    logic [31:0] ed;
    es   = ref_strb(a[1:0], f3);
    ed   = ref_pos(d, a[1:0], f3);
    nw0  = wlog.size();
    nrd0 = rdlog.size();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_ctrl = f3; cpu_addr = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    low_cnt = low;
    busy = 0; n = 0; rv_seen = 0;
    while (cpu_ready !== 1'b1 && n < 100) begin
      busy++;
      if (cpu_rvalid === 1'b1) rv_seen = 1;
      @(posedge clk); #1;
      n++;
    end
    if (!rand_ready) chk({tg, "_busy"}, 32'(busy), 32'(low + 1));
    chk({tg, "_no_rvalid"}, 32'(rv_seen), 32'd0);
    chk({tg, "_no_refill"}, 32'(rdlog.size() - nrd0), 32'd0);
    chk({tg, "_nwrite"}, 32'(wlog.size() - nw0), 32'd1);
    if (wlog.size() == nw0 + 1) begin
      chk({tg, "_addr"}, 32'(wlog[nw0].a), 32'({a[11:2], 2'b00}));
      chk({tg, "_strb"}, 32'(wlog[nw0].s), 32'(es));
      chk({tg, "_data"}, wlog[nw0].d & strb_mask(es), ed & strb_mask(es));
    end
    ref_mem[a[11:2]] = (ref_mem[a[11:2]] & ~strb_mask(es)) | (ed & strb_mask(es));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          n;
    bit          bad;
    int          r0, nw0;
    logic [11:0] ra;
    logic [2:0]  rf;

    for (int i = 0; i < 1024; i++) begin
      bmem[i]    = $urandom;
      ref_mem[i] = bmem[i];
    end
    bmem[16] = 32'h11; bmem[17] = 32'h22; bmem[18] = 32'h33; bmem[19] = 32'h44;
    for (int i = 16; i < 20; i++) ref_mem[i] = bmem[i];
    for (int s = 0; s < 16; s++) begin m_valid[s] = 0; m_tag[s] = '0; end

    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_ready", 32'(cpu_ready), 32'd1);
    chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_memreq", {30'd0, mem_req, mem_we}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);

    // Cold miss then hits
    mem_lat = 2;
    do_load(12'h040, 3'b010, "cold");
    do_load(12'h048, 3'b010, "hit48");
    n = rdlog.size();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_ctrl = 3'b010; cpu_addr = 12'h044;
    @(posedge clk); #1;
    chk("b2b_first", {cpu_rvalid, cpu_rdata[30:0]}, {1'b1, 31'h22});
    cpu_addr = 12'h04C;
    @(posedge clk); #1;
    chk("b2b_second", {cpu_rvalid, cpu_rdata[30:0]}, {1'b1, 31'h44});
    cpu_req = 1'b0;
    chk("b2b_nomem", 32'(rdlog.size() - n), 32'd0);

    // Sizing
    do_store(12'h040, 3'b010, 32'h80FF7F01, 0, "sw40");
    do_load(12'h043, 3'b000, "lb43");
    chk("lb43_val", ref_load(ref_mem[16], 2'd3, 3'b000), 32'hFFFFFF80);
    do_load(12'h043, 3'b100, "lbu43");
    do_load(12'h042, 3'b001, "lh42");
    do_load(12'h040, 3'b101, "lhu40");
    do_load(12'h041, 3'b011, "lw_rsvd");

    // Store hit byte
    nw0 = wlog.size();
    do_store(12'h041, 3'b000, 32'h000000AB, 0, "sb41");
    if (wlog.size() > nw0) chk("sb41_full_data", wlog[nw0].d, 32'hABABABAB);
    do_load(12'h040, 3'b010, "lw40_after_sb");

    // Store miss with memory stall
    do_store(12'h100, 3'b010, 32'hDEADBEEF, 3, "swmiss");
    do_load(12'h100, 3'b010, "lw100");

    // Reset mid-refill
    mem_lat = 3;
    r0 = rets;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_ctrl = 3'b010; cpu_addr = 12'h300;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    n = 0;
    while (rets < r0 + 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_two_returns", 32'(rets >= r0 + 2), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("mid_rst_state", {30'd0, cpu_ready, mem_req}, 32'd2);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (cpu_rvalid !== 1'b0 || mem_req !== 1'b0 || cpu_ready !== 1'b1) bad = 1;
      @(posedge clk); #1;
    end
    chk("mid_late_ignored", 32'(bad), 32'd0);
    chk("mid_queue_drained", 32'(rq.size()), 32'd0);
    for (int s = 0; s < 16; s++) m_valid[s] = 0;
    do_load(12'h040, 3'b010, "lw40_after_rst");
    do_load(12'h300, 3'b010, "lw300");

    // Random mix
    for (int i = 0; i < 150; i++) begin
      rand_ready = ($urandom_range(0, 1) == 1);
      mem_lat    = $urandom_range(1, 4);
      ra         = 12'($urandom_range(0, 12'h3FF));
      if ($urandom_range(0, 2) == 0) begin
        rf = 3'($urandom_range(0, 2));
        do_store(ra, rf, $urandom, 0, "rnd_st");
      end else begin
        rf = 3'($urandom_range(0, 7));
        do_load(ra, rf, "rnd_ld");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate L1 data cache: the responder for the CPU's load/store port in the pipelined-plus-cache core. It accepts one request per cycle over a valid/ready handshake, answers hits in one cycle, and refills 4-word lines from a word-wide backing memory on read misses. It handles RISC-V byte, halfword and word sizing (funct3) on both loads and stores, replacing the single-cycle `data_memory` on the CPU side.

## Interface
- `DATA_WIDTH`, 32, word width; only 32 is supported.
- `ADDR_WIDTH`, 12, byte address width.
- `SETS`, 16, number of lines; must be a power of 2. Index = log2(SETS) bits, offset = 4 bits, tag = the remaining bits (4 at defaults).
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous and active-low.
- `cpu_req` in 1: request valid.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_ctrl` in 3: funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `cpu_addr` in ADDR_WIDTH: byte address.
- `cpu_wdata` in 32: store data, taken from the low bytes.
- `cpu_ready` out 1: request accepted when `cpu_req & cpu_ready`.
- `cpu_rvalid` out 1: one-cycle pulse; load data valid.
- `cpu_rdata` out 32: sized and extended load data.
- `mem_req` out 1: backing-memory request valid.
- `mem_we` out 1: write request.
- `mem_addr` out ADDR_WIDTH: word-aligned address (bits [1:0] = 0).
- `mem_wdata` out 32: write data, already byte-lane positioned.
- `mem_wstrb` out 4: byte enables for writes.
- `mem_ready` in 1: memory accepts the request this cycle.
- `mem_rvalid` in 1: read word returned. Returns are in order, at any latency ≥ 1.
- `mem_rdata` in 32: read word.

## Operation
- FSM states: IDLE, REFILL, RESPOND, WRITE. `cpu_ready` = (state == IDLE).
- Address split: addr[1:0] = byte, addr[3:2] = word, then index, then tag.
- **Load hit in IDLE:** the result is registered and `cpu_rvalid` is asserted the next cycle. The FSM stays in IDLE.
- **Load miss:** the address is latched and the FSM goes to REFILL.
  - Issue 4 read requests at line base + 0, 4, 8, 12, advanced by a 2-bit issue counter on `mem_ready`.
  - Returns are counted by a separate 2-bit counter; each returned word is written into the line.
  - On the 4th return: set the tag and valid bit, then go to RESPOND.
- **RESPOND:** drive `cpu_rvalid` = 1 with the extracted word for one cycle, then go to IDLE.
- **Store (hit or miss):**
  - On a hit, the cached word is byte-merged per `mem_wstrb` on the accept edge.
  - On a miss, the cache is unchanged.
  - The request data is latched and the FSM goes to WRITE.
- **WRITE:** hold `mem_req` = `mem_we` = 1 until `mem_ready`, then go to IDLE. Stores produce no `cpu_rvalid`.
- **Load extract:**
  - B and H sign-extend; BU and HU zero-extend.
  - H and HU select the halfword with addr[1]; W ignores addr[1:0].
- **Store merge:**
  - SB replicates the byte to all lanes with strobe 1 << addr[1:0].
  - SH uses strobe 0011 or 1100 per addr[1].
  - SW uses strobe 1111.
- Undefined funct3 (011, 110, 111) is treated as W. Misalignment is not detected.

## Timing
- **Reset (`rst` = 0 at an edge):** all valid bits are cleared, state = IDLE, counters = 0. `cpu_rvalid` = 0, `mem_req` = 0, `mem_we` = 0, `cpu_rdata` = 0, `cpu_ready` = 1 once `rst` is high.
- **Reset mid-refill or mid-write:** the transaction is abandoned. `mem_rvalid` arriving after reset is ignored, because only REFILL consumes it.
- **Hit latency:** 1 cycle. Back-to-back load hits sustain 1 per cycle.
- **Miss latency:** 4 issue cycles (minimum) plus memory return time plus 1 RESPOND cycle.
- **Store occupancy:** 1 accept cycle plus at least 1 WRITE cycle.
- `mem_rvalid` may arrive in the same cycle as a later request issue; both counters advance independently.
- REFILL ends only when the return count reaches 4. Issue stops after 4 requests (`mem_req` = 0) even while returns are still pending.
- A load to the same index as the line being refilled cannot arrive, because `cpu_ready` = 0.
- The stored tag and data are updated on the same edge that sets the valid bit.

## Structure
- Package `data_cache_pkg`:
  - state enum `dc_state_e`;
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - offset width constant;
  - functions for tag and index width from the parameters.
- Sub-module `mem_align`: purely combinational. Performs load extract (word + addr[1:0] + funct3 → `rdata`) and store merge (`wdata` + addr + funct3 → positioned data + strobe). It is instantiated once and shared by the hit and RESPOND paths.
- Tag, valid and data arrays are flop arrays (no SRAM macro).

## Test plan
- **Reset then cold miss:** LW at 0x040; memory returns 0x11, 0x22, 0x33, 0x44 with 2-cycle latency. Required: 4 requests at 0x040/044/048/04C, then `cpu_rvalid` with `cpu_rdata` = 0x11.
- **Hit after refill:** LW 0x048 → `cpu_rvalid` next cycle, data 0x33, no `mem_req`. Back-to-back LW 0x044 and LW 0x04C → 0x22 then 0x44 on consecutive cycles.
- **Sizing:** the word at 0x040 holds 0x80FF7F01.
  - LB 0x043 → 0xFFFFFF80; LBU 0x043 → 0x00000080.
  - LH 0x042 → 0xFFFF80FF; LHU 0x040 → 0x00007F01.
- **Store hit:** SB 0x041 with data 0xAB → `mem_wstrb` = 0010, `mem_wdata` = 0xABABABAB. A following LW 0x040 hits with 0x80FFAB01.
- **Store miss:** SW 0x100 with data 0xDEADBEEF while `mem_ready` is held low for 3 cycles. Required: `cpu_ready` = 0 for 4 cycles, `mem_addr` = 0x100, no refill. A following LW 0x100 misses.
- **Reset mid-refill:** assert `rst` after 2 returns. Required: IDLE, `mem_req` = 0; late `mem_rvalid` is ignored, and LW 0x040 misses again.
